matrix_scroller: RTL and testbench

MATRIX_SCROLLER -- requirements
Module: matrix_scroller

---
 rtl/matrix_pkg.sv | 29 ++
 rtl/matrix_font_rom.sv | 13 +
 rtl/matrix_scroller.sv | 87 ++++++++
 tb/tb_matrix_scroller.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: glyph codes, scroller FSM states and the 8x8 glyph bitmap table
package matrix_pkg;
    localparam int unsigned CODE_BLANK = 0;
    localparam int unsigned CODE_H = 1;
    localparam int unsigned CODE_E = 2;
    localparam int unsigned CODE_L = 3;
    localparam int unsigned CODE_O = 4;

    typedef enum logic [1:0] {FETCH_CUR, FETCH_NXT, BUILD, OFFER} state_t;

    localparam logic [63:0] GLYPH_TABLE [8] = '{
        64'h0,
        64'he0606c766666e600,
        64'h000078ccfcc07800,
        64'h7030303030307800,
        64'h000078cccccc7800,
        64'h0,
        64'h0,
        64'h0
    };

    localparam int unsigned DEFAULT_MSG [8] = '{
        CODE_H, CODE_E, CODE_L, CODE_L, CODE_O, CODE_BLANK, CODE_BLANK, CODE_BLANK
    };

    function automatic logic [63:0] glyph_bitmap(input int unsigned code);
        return code < 8 ? GLYPH_TABLE[code[2:0]] : 64'h0;
    endfunction
endpackage

// File: rtl/matrix_font_rom.sv
// matrix_font_rom: glyph code to 8x8 bitmap, one-cycle registered read
module matrix_font_rom
    import matrix_pkg::*;
#(
    parameter int GLYPH_W = 3
) (
    input  logic               clk,
    input  logic [GLYPH_W-1:0] code,
    output logic [63:0]        bitmap
);
    always_ff @(posedge clk)
        bitmap <= glyph_bitmap(32'(code));
endmodule

// File: rtl/matrix_scroller.sv
// matrix_scroller: scrolls a buffered message across an 8x8 frame, one pixel per accepted frame
module matrix_scroller
    import matrix_pkg::*;
#(
    parameter int GLYPH_W = 3,
    parameter int MSG_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [GLYPH_W-1:0] wr_code,
    input  logic [3:0]         msg_len,
    output logic [63:0]        frame,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [2:0]         frame_letter,
    output logic [2:0]         frame_shift
);
    state_t state, state_nxt;
    logic [GLYPH_W-1:0] buffer [MSG_DEPTH];
    logic [GLYPH_W-1:0] rom_code;
    logic [63:0] rom_q, cur_q, composed;
    logic [3:0] eff_len, letter_inc;
    logic [2:0] letter, shift, nxt_idx;
    logic accept;

    assign eff_len = msg_len > 4'd8 ? 4'd8 : msg_len;
    assign letter_inc = {1'b0, letter} + 4'd1;
    assign nxt_idx = letter_inc >= eff_len ? 3'd0 : letter_inc[2:0];
    assign frame_valid = state == OFFER;
    assign accept = frame_valid & frame_ready;
    assign frame_letter = letter;
    assign frame_shift = shift;
    assign rom_code = state == FETCH_CUR ? buffer[letter] : buffer[nxt_idx];

    matrix_font_rom #(.GLYPH_W(GLYPH_W)) u_rom (
        .clk(clk),
        .code(rom_code),
        .bitmap(rom_q)
    );

    always_comb
        state_nxt = state == FETCH_CUR ? FETCH_NXT :
                    state == FETCH_NXT ? BUILD :
                    state == BUILD     ? OFFER :
                    accept             ? FETCH_CUR : OFFER;

    // rom_q holds the next-character bitmap while in BUILD; shifting the row pair left
    // and keeping the upper byte gives (cur << s) | (nxt >> (8 - s)).
    always_comb begin
        composed = '0;
        for (int r = 0; r < 8; r++)
            composed[63-8*r -: 8] = 8'(({cur_q[63-8*r -: 8], rom_q[63-8*r -: 8]} << shift) >> 8);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH_CUR;
            frame <= '0;
            cur_q <= '0;
            letter <= '0;
            shift <= '0;
            for (int i = 0; i < MSG_DEPTH; i++)
                buffer[i] <= GLYPH_W'(DEFAULT_MSG[i]);
        end else begin
            state <= state_nxt;
            if (wr_en)
                buffer[wr_addr] <= wr_code;
            if (state == FETCH_NXT)
                cur_q <= rom_q;
            if (state == BUILD)
                frame <= eff_len == 4'd0 ? '0 : composed;
            if (accept) begin
                if (eff_len == 4'd0 || {1'b0, letter} >= eff_len) begin
                    letter <= '0;
                    shift <= '0;
                end else if (shift == 3'd7) begin
                    letter <= nxt_idx;
                    shift <= '0;
                end else begin
                    shift <= shift + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_scroller.sv
// tb_matrix_scroller: table vectors, corner sequences and randomized checks against a scroll model
module tb_matrix_scroller;
    logic clk = 0;
    logic reset = 1;
    logic wr_en = 0;
    logic [2:0] wr_addr = 0;
    logic [2:0] wr_code = 0;
    logic [3:0] msg_len = 5;
    logic [63:0] frame;
    logic frame_valid;
    logic frame_ready = 0;
    logic [2:0] frame_letter;
    logic [2:0] frame_shift;

    int errors = 0;
    int checks = 0;

    int mbuf [8];
    int m_letter, m_shift;

    localparam logic [63:0] H_FRAME = 64'he0606c766666e600;
    localparam logic [63:0] O_FRAME = 64'h000078cccccc7800;

    typedef struct {
        int accepts;
        int letter;
        int shift;
        int row;
        int row_val;
    } vec_t;

    vec_t vecs [8];

    matrix_scroller #(.GLYPH_W(3), .MSG_DEPTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_code(wr_code),
        .msg_len(msg_len),
        .frame(frame),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_letter(frame_letter),
        .frame_shift(frame_shift)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] glyph(int c);
        case (c)
            1: return 64'he0606c766666e600;
            2: return 64'h000078ccfcc07800;
            3: return 64'h7030303030307800;
            4: return 64'h000078cccccc7800;
            default: return 64'h0;
        endcase
    endfunction

    function automatic int eff_len();
        return msg_len > 8 ? 8 : int'(msg_len);
    endfunction

    function automatic logic [63:0] model_frame();
        int len = eff_len();
        logic [63:0] cur, nxt, f;
        int cr, nr;
        f = 0;
        if (len == 0) return f;
        cur = glyph(mbuf[m_letter]);
        nxt = glyph(mbuf[(m_letter + 1) % len]);
        for (int r = 0; r < 8; r++) begin
            cr = int'(cur[63-8*r -: 8]);
            nr = int'(nxt[63-8*r -: 8]);
            f[63-8*r -: 8] = 8'(((cr << m_shift) | (nr >> (8 - m_shift))) & 255);
        end
        return f;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(string name);
        int n = 0;
        while (!frame_valid && n < 20) begin
            tick();
            n++;
        end
        if (!frame_valid) begin
            errors++;
            checks++;
            $display("FAIL %s: frame_valid got 0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic check_offer(string name);
        check({name, " frame"}, frame, model_frame());
        check({name, " letter"}, 64'(frame_letter), 64'(m_letter));
        check({name, " shift"}, 64'(frame_shift), 64'(m_shift));
    endtask

    task automatic model_accept();
        int len = eff_len();
        if (len == 0 || m_letter >= len) begin
            m_letter = 0;
            m_shift = 0;
        end else if (m_shift == 7) begin
            m_shift = 0;
            m_letter = (m_letter + 1 >= len) ? 0 : m_letter + 1;
        end else begin
            m_shift++;
        end
    endtask

    task automatic do_accept();
        frame_ready = 1;
        tick();
        frame_ready = 0;
        model_accept();
    endtask

    task automatic next_frame(string name);
        wait_valid(name);
        do_accept();
        wait_valid(name);
    endtask

    task automatic write(int addr, int code);
        wr_en = 1;
        wr_addr = 3'(addr);
        wr_code = 3'(code);
        tick();
        wr_en = 0;
        mbuf[addr] = code;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
        mbuf = '{1, 2, 3, 3, 4, 0, 0, 0};
        m_letter = 0;
        m_shift = 0;
    endtask

    initial begin
        logic [63:0] held_frame;
        logic [2:0] held_letter, held_shift;
        int cnt;
        vecs[0] = '{0, 0, 0, 0, 'he0};
        vecs[1] = '{1, 0, 1, 0, 'hc0};
        vecs[2] = '{7, 0, 7, 0, 'h00};
        vecs[3] = '{8, 1, 0, 2, 'h78};
        vecs[4] = '{12, 1, 4, 2, 'h83};
        vecs[5] = '{19, 2, 3, 0, 'h83};
        vecs[6] = '{39, 4, 7, 0, 'h70};
        vecs[7] = '{40, 0, 0, 0, 'he0};

        @(negedge clk);
        msg_len = 5;
        do_reset();
        reset = 1;
        check("reset valid", 64'(frame_valid), 0);
        check("reset frame", frame, 0);
        check("reset letter", 64'(frame_letter), 0);
        check("reset shift", 64'(frame_shift), 0);
        reset = 0;
        tick();
        check("release +1 valid", 64'(frame_valid), 0);
        tick();
        check("release +2 valid", 64'(frame_valid), 0);
        tick();
        check("release +3 valid", 64'(frame_valid), 1);
        check("first frame", frame, H_FRAME);

        cnt = 0;
        foreach (vecs[i]) begin
            while (cnt < vecs[i].accepts) begin
                wait_valid("table advance");
                do_accept();
                cnt++;
            end
            wait_valid("table");
            check($sformatf("vec%0d letter", i), 64'(frame_letter), 64'(vecs[i].letter));
            check($sformatf("vec%0d shift", i), 64'(frame_shift), 64'(vecs[i].shift));
            check($sformatf("vec%0d row%0d", i, vecs[i].row), 64'(frame[63-8*vecs[i].row -: 8]), 64'(vecs[i].row_val));
        end
        check("wrap frame equals first", frame, H_FRAME);

        do_accept();
        check("gap +1 valid", 64'(frame_valid), 0);
        tick();
        check("gap +2 valid", 64'(frame_valid), 0);
        tick();
        check("gap +3 valid", 64'(frame_valid), 0);
        tick();
        check("gap +4 valid", 64'(frame_valid), 1);

        held_frame = frame;
        held_letter = frame_letter;
        held_shift = frame_shift;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("backpressure %0d hold", i),
                  {frame_valid, frame_letter, frame_shift, frame},
                  {1'b1, held_letter, held_shift, held_frame});
        end
        do_accept();
        wait_valid("after backpressure");
        check("backpressure shift advance", 64'(frame_shift), 64'(held_shift + 3'd1));
        check_offer("after backpressure");

        do_reset();
        wait_valid("write test");
        write(0, 4);
        check("write keeps offered frame", frame, H_FRAME);
        for (int i = 0; i < 40; i++) next_frame("write return");
        check("write return letter", 64'(frame_letter), 0);
        check("write return frame", frame, O_FRAME);

        msg_len = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wait_valid("len0");
            check($sformatf("len0 frame %0d", i), frame, 0);
            check($sformatf("len0 pos %0d", i), {61'(frame_letter), frame_shift}, 0);
            do_accept();
        end
        msg_len = 5;
        cnt = 0;
        while (!(m_letter == 3 && m_shift == 4) && cnt < 100) begin
            next_frame("shrink advance");
            cnt++;
        end
        check_offer("shrink mid");
        msg_len = 2;
        next_frame("shrink");
        check("shrink letter", 64'(frame_letter), 0);
        check("shrink shift", 64'(frame_shift), 0);
        check("shrink frame", frame, H_FRAME);

        msg_len = 5;
        wait_valid("reset mid");
        write(0, 2);
        reset = 1;
        tick();
        reset = 0;
        check("reset mid valid", 64'(frame_valid), 0);
        mbuf = '{1, 2, 3, 3, 4, 0, 0, 0};
        m_letter = 0;
        m_shift = 0;
        wait_valid("reset mid");
        check("reset mid frame", frame, H_FRAME);

        msg_len = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wait_valid("self scroll");
            check_offer($sformatf("self scroll %0d", i));
            do_accept();
        end

        msg_len = 5;
        do_reset();
        for (int i = 0; i < 250; i++) begin
            wait_valid("random");
            check_offer($sformatf("random %0d", i));
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                if ($urandom_range(0, 1) == 1) write($urandom_range(0, 7), $urandom_range(0, 7));
                else tick();
            end
            if ($urandom_range(0, 15) == 0) msg_len = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 7) == 0) msg_len = 4'($urandom_range(1, 8));
            do_accept();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
